voice_allocator: RTL and testbench

Sequences the synth's polyphonic voice resources. It accepts decoded MIDI note-on/note-off events through a valid/ready handshake and assigns each note to one of NUM_VOICES voice slots. When all slots are busy, it steals the least-recently-assigned voice. Sits between the MIDI decoder and the per-voice oscillator datapath, in the clock_50_000_000 domain; its voice table drives the sample-rate datapath.

---
 rtl/voice_allocator_pkg.sv | 20 ++
 rtl/voice_lru.sv | 42 ++++
 rtl/voice_allocator.sv | 189 ++++++++++++++++++
 tb/tb_voice_allocator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared constants, voice-table types and allocator FSM states for voice_allocator.
package voice_allocator_pkg;
  localparam int NUM_VOICES = 8;
  localparam int NOTE_WIDTH = 7;
  localparam int VEL_WIDTH  = 7;
  localparam int IDX_W      = $clog2(NUM_VOICES);

  typedef logic [NOTE_WIDTH-1:0] note_t;
  typedef logic [VEL_WIDTH-1:0]  velocity_t;
  typedef logic [IDX_W-1:0]      idx_t;

  typedef struct packed {
    logic      active;
    logic      held;
    note_t     note;
    velocity_t velocity;
  } voice_t;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} alloc_state_t;
endpackage

// File: rtl/voice_lru.sv
// Per-slot age permutation; a touch makes the slot youngest and ages every younger slot by one.
// oldest_idx is combinational from the registered ages; touch takes effect on the next edge.
module voice_lru
  import voice_allocator_pkg::*;
(
  input  logic clock_50_000_000,
  input  logic reset_l,
  input  logic touch,
  input  idx_t touch_idx,
  output idx_t oldest_idx
);
  idx_t age_q [NUM_VOICES];
  idx_t age_d [NUM_VOICES];

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      age_d[i] = age_q[i];
      if (touch) begin
        if (idx_t'(i) == touch_idx) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[touch_idx]) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    oldest_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (age_q[i] == idx_t'(NUM_VOICES - 1)) oldest_idx = idx_t'(i);
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= idx_t'(i);
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= age_d[i];
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: one event per NUM_VOICES+2 cycles, LRU stealing; all_off aborts and blocks ev_ready.
// Optional sustain pedal (held voices, release on pedal fall) is built when SUSTAIN_PEDAL_EN is defined.
module voice_allocator
  import voice_allocator_pkg::*;
(
  input  logic                             clock_50_000_000,
  input  logic                             reset_l,
  input  logic                             ev_valid,
  output logic                             ev_ready,
  input  logic                             ev_on,
  input  logic [NOTE_WIDTH-1:0]            ev_note,
  input  logic [VEL_WIDTH-1:0]             ev_velocity,
  input  logic                             all_off,
`ifdef SUSTAIN_PEDAL_EN
  input  logic                             sustain,
`endif
  output logic [NUM_VOICES-1:0]            voice_active,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
  output logic [NUM_VOICES*VEL_WIDTH-1:0]  voice_velocity,
  output logic [NUM_VOICES-1:0]            voice_trigger,
  output logic                             stolen
);
  alloc_state_t state_q, state_d;
  idx_t idx_q, idx_d, match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic match_vld_q, match_vld_d, free_vld_q, free_vld_d;
  logic on_q, on_d, stolen_q, stolen_d, ev_ready_q, ev_ready_d;
  note_t note_q, note_d;
  velocity_t vel_q, vel_d;
  voice_t voices_q [NUM_VOICES];
  voice_t voices_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] trigger_q, trigger_d;
  voice_t cur;
  idx_t slot, oldest_idx;
  logic touch, accept, sus_release, hold_off;

`ifdef SUSTAIN_PEDAL_EN
  logic sustain_q, sustain_d, sus_ev_q, sus_ev_d;
  assign sus_release = (state_q == IDLE) && sustain_q && !sustain;
  assign hold_off    = sus_ev_q;
  assign sustain_d   = (state_q == IDLE) ? sustain : sustain_q;
  assign sus_ev_d    = accept ? sustain : sus_ev_q;

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      sustain_q <= 1'b0;
      sus_ev_q  <= 1'b0;
    end else begin
      sustain_q <= sustain_d;
      sus_ev_q  <= sus_ev_d;
    end
  end
`else
  assign sus_release = 1'b0;
  assign hold_off    = 1'b0;
`endif

  assign ev_ready = ev_ready_q && (state_q == IDLE) && !all_off && !sus_release;
  assign accept   = ev_valid && ev_ready;

  voice_lru u_lru (
    .clock_50_000_000 (clock_50_000_000),
    .reset_l          (reset_l),
    .touch            (touch),
    .touch_idx        (slot),
    .oldest_idx       (oldest_idx)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    on_d        = on_q;
    note_d      = note_q;
    vel_d       = vel_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    voices_d    = voices_q;
    trigger_d   = '0;
    stolen_d    = 1'b0;
    ev_ready_d  = 1'b0;
    touch       = 1'b0;
    slot        = '0;
    cur         = voices_q[idx_q];
    if (all_off) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        voices_d[i].active = 1'b0;
        voices_d[i].held   = 1'b0;
      end
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          ev_ready_d = !accept;
          if (sus_release) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (voices_q[i].held) begin
                voices_d[i].active = 1'b0;
                voices_d[i].held   = 1'b0;
              end
            end
          end
          if (accept) begin
            // velocity-0 note-on is folded into note-off here so SCAN/COMMIT see one flag
            on_d        = ev_on && (ev_velocity != '0);
            note_d      = ev_note;
            vel_d       = ev_velocity;
            idx_d       = '0;
            match_vld_d = 1'b0;
            free_vld_d  = 1'b0;
            state_d     = SCAN;
          end
        end
        SCAN: begin
          if (cur.active && (cur.note == note_q) && !match_vld_q) begin
            match_vld_d = 1'b1;
            match_idx_d = idx_q;
          end
          if (!cur.active && !free_vld_q) begin
            free_vld_d = 1'b1;
            free_idx_d = idx_q;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == idx_t'(NUM_VOICES - 1)) state_d = COMMIT;
        end
        COMMIT: begin
          state_d = IDLE;
          if (on_q) begin
            slot     = match_vld_q ? match_idx_q : (free_vld_q ? free_idx_q : oldest_idx);
            stolen_d = !match_vld_q && !free_vld_q;
            voices_d[slot].active   = 1'b1;
            voices_d[slot].held     = 1'b0;
            voices_d[slot].note     = note_q;
            voices_d[slot].velocity = vel_q;
            trigger_d[slot] = 1'b1;
            touch           = 1'b1;
          end else if (match_vld_q) begin
            if (hold_off) voices_d[match_idx_q].held   = 1'b1;
            else          voices_d[match_idx_q].active = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      on_q        <= 1'b0;
      note_q      <= '0;
      vel_q       <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      trigger_q   <= '0;
      stolen_q    <= 1'b0;
      ev_ready_q  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) voices_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      on_q        <= on_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      trigger_q   <= trigger_d;
      stolen_q    <= stolen_d;
      ev_ready_q  <= ev_ready_d;
      for (int i = 0; i < NUM_VOICES; i++) voices_q[i] <= voices_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_active[i]                              = voices_q[i].active;
      voice_note[i*NOTE_WIDTH +: NOTE_WIDTH]       = voices_q[i].note;
      voice_velocity[i*VEL_WIDTH +: VEL_WIDTH]     = voices_q[i].velocity;
    end
  end

  assign voice_trigger = trigger_q;
  assign stolen        = stolen_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a behavioural voice model predicts each event's outcome at acceptance.
module tb_voice_allocator;
  import voice_allocator_pkg::*;
  localparam int NV = NUM_VOICES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ev_valid = 1'b0, ev_on = 1'b0, all_off = 1'b0, sustain = 1'b0;
  note_t ev_note = '0;
  velocity_t ev_velocity = '0;
  logic ev_ready, stolen;
  logic [NV-1:0] voice_active, voice_trigger;
  logic [NV*NOTE_WIDTH-1:0] voice_note;
  logic [NV*VEL_WIDTH-1:0] voice_velocity;

  typedef struct packed {
    logic [NV-1:0] trig;
    logic          stolen;
  } exp_t;
  exp_t sb[$];

  logic      m_active [NV];
  logic      m_held   [NV];
  note_t     m_note   [NV];
  velocity_t m_vel    [NV];
  int        m_age    [NV];

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  voice_allocator dut (
    .clock_50_000_000 (clk),
    .reset_l          (rst_n),
    .ev_valid         (ev_valid),
    .ev_ready         (ev_ready),
    .ev_on            (ev_on),
    .ev_note          (ev_note),
    .ev_velocity      (ev_velocity),
    .all_off          (all_off),
`ifdef SUSTAIN_PEDAL_EN
    .sustain          (sustain),
`endif
    .voice_active     (voice_active),
    .voice_note       (voice_note),
    .voice_velocity   (voice_velocity),
    .voice_trigger    (voice_trigger),
    .stolen           (stolen)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_active[i] = 1'b0; m_held[i] = 1'b0; m_note[i] = '0; m_vel[i] = '0; m_age[i] = i;
    end
  endtask

  task automatic model_apply(input logic on, input note_t note, input velocity_t vel,
                             input logic sus, output exp_t e);
    int slot;
    int old;
    slot = -1;
    e = '0;
    if (on && vel != 0) begin
      for (int i = 0; i < NV; i++) if (slot < 0 && m_active[i] && m_note[i] == note) slot = i;
      if (slot < 0) for (int i = 0; i < NV; i++) if (slot < 0 && !m_active[i]) slot = i;
      if (slot < 0) begin
        for (int i = 0; i < NV; i++) if (m_age[i] == NV - 1) slot = i;
        e.stolen = 1'b1;
      end
      old = m_age[slot];
      for (int i = 0; i < NV; i++) if (m_age[i] < old) m_age[i]++;
      m_age[slot] = 0;
      m_active[slot] = 1'b1; m_held[slot] = 1'b0; m_note[slot] = note; m_vel[slot] = vel;
      e.trig[slot] = 1'b1;
    end else begin
      for (int i = 0; i < NV; i++) if (slot < 0 && m_active[i] && m_note[i] == note) slot = i;
      if (slot >= 0) begin
        if (sus) m_held[slot] = 1'b1;
        else     m_active[slot] = 1'b0;
      end
    end
  endtask

  task automatic check_table(input string tag);
    logic [NV-1:0] a;
    logic [NV*NOTE_WIDTH-1:0] n;
    logic [NV*VEL_WIDTH-1:0] v;
    for (int i = 0; i < NV; i++) begin
      a[i] = m_active[i];
      n[i*NOTE_WIDTH +: NOTE_WIDTH] = m_note[i];
      v[i*VEL_WIDTH +: VEL_WIDTH] = m_vel[i];
    end
    check_val({tag, "_active"}, 64'(voice_active), 64'(a));
    check_val({tag, "_note"}, 64'(voice_note), 64'(n));
    check_val({tag, "_vel"}, 64'(voice_velocity), 64'(v));
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!ev_ready && k < 50) begin @(negedge clk); k++; end
    if (!ev_ready) check_val({tag, "_ready_timeout"}, 64'(ev_ready), 64'd1);
  endtask

  task automatic send_event(input string tag, input logic on, input note_t note, input velocity_t vel);
    exp_t e, got;
    int trig_k, rdy_k, extra;
    wait_ready(tag);
    if (!ev_ready) return;
    ev_valid = 1'b1; ev_on = on; ev_note = note; ev_velocity = vel;
    @(posedge clk);
    model_apply(on, note, vel, sustain, e);
    sb.push_back(e);
    @(negedge clk);
    ev_valid = 1'b0;
    ev_on = 1'($urandom_range(0, 1));
    ev_note = note_t'($urandom);
    ev_velocity = velocity_t'($urandom);
    trig_k = 0; rdy_k = 0; extra = 0; got = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (voice_trigger != '0 || stolen) begin
        if (trig_k == 0) begin trig_k = c; got.trig = voice_trigger; got.stolen = stolen; end
        else extra++;
      end
      if (ev_ready) begin rdy_k = c; break; end
    end
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check_val({tag, "_trigger"}, 64'(got.trig), 64'(e.trig));
    check_val({tag, "_stolen"}, 64'(got.stolen), 64'(e.stolen));
    check_val({tag, "_trig_cycle"}, 64'(trig_k), (e.trig != '0) ? 64'd9 : 64'd0);
    check_val({tag, "_extra_pulse"}, 64'(extra), 64'd0);
    check_val({tag, "_ready_cycle"}, 64'(rdy_k), 64'd10);
    check_table(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int trig_seen;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_ready", 64'(ev_ready), 64'd0);
    check_val("rst_trigger", 64'(voice_trigger), 64'd0);
    check_val("rst_stolen", 64'(stolen), 64'd0);
    check_table("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_reset", 64'(ev_ready), 64'd1);

    send_event("first_on", 1'b1, 7'd60, 7'd100);
    for (int n = 61; n <= 67; n++) send_event("fill", 1'b1, note_t'(n), 7'd90);
    send_event("steal72", 1'b1, 7'd72, 7'd80);
    send_event("steal73", 1'b1, 7'd73, 7'd70);

    // async reset while an event is mid-scan
    wait_ready("midrst");
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd90; ev_velocity = 7'd33;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_active", 64'(voice_active), 64'd0);
    check_val("midrst_ready", 64'(ev_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    trig_seen = 0;
    repeat (12) begin @(negedge clk); if (voice_trigger != '0) trig_seen++; end
    check_val("midrst_no_trigger", 64'(trig_seen), 64'd0);
    check_table("midrst");

    send_event("retrig_a", 1'b1, 7'd60, 7'd100);
    send_event("retrig_b", 1'b1, 7'd60, 7'd40);
    send_event("on64", 1'b1, 7'd64, 7'd100);
    send_event("off64_vel0", 1'b1, 7'd64, 7'd0);
    send_event("off50_absent", 1'b0, 7'd50, 7'd0);
    send_event("on62", 1'b1, 7'd62, 7'd20);
    send_event("on63", 1'b1, 7'd63, 7'd30);

    // all_off in the middle of a fourth note-on's scan
    wait_ready("alloff");
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd70; ev_velocity = 7'd99;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    all_off = 1'b1;
    #1;
    check_val("alloff_ready_low", 64'(ev_ready), 64'd0);
    @(negedge clk);
    check_val("alloff_active", 64'(voice_active), 64'd0);
    check_val("alloff_ready_held", 64'(ev_ready), 64'd0);
    all_off = 1'b0;
    @(negedge clk);
    check_val("alloff_ready_after", 64'(ev_ready), 64'd1);
    for (int i = 0; i < NV; i++) begin m_active[i] = 1'b0; m_held[i] = 1'b0; end
    trig_seen = 0;
    repeat (12) begin @(negedge clk); if (voice_trigger != '0) trig_seen++; end
    check_val("alloff_dropped", 64'(trig_seen), 64'd0);
    check_table("alloff");
    send_event("after_alloff", 1'b1, 7'd71, 7'd55);

`ifdef SUSTAIN_PEDAL_EN
    sustain = 1'b1;
    @(negedge clk);
    send_event("sus_on", 1'b1, 7'd60, 7'd100);
    send_event("sus_off", 1'b0, 7'd60, 7'd0);
    sustain = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NV; i++) if (m_held[i]) begin m_active[i] = 1'b0; m_held[i] = 1'b0; end
    check_table("sus_release");
`endif

    for (int r = 0; r < 40; r++) begin
      logic on;
      note_t nt;
      velocity_t vl;
      on = ($urandom_range(0, 3) != 0);
      nt = note_t'(60 + $urandom_range(0, 11));
      vl = velocity_t'($urandom_range(1, 127));
      if ($urandom_range(0, 7) == 0) vl = '0;
      send_event("rand", on, nt, vl);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
